pipe_ctrl: RTL

Central pipeline controller for the 5-stage core. It merges per-stage stall requests into the 8-bit stall vector consumed by the if_id/id_ex/ex_mem/mem_wb registers, and turns MEM-stage exceptions into a flush pulse plus redirect PC. It holds flush for a configurable number of cycles, masks new exceptions during that window, and keeps stall-cycle statistics with a sticky stall-timeout flag.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the central pipeline controller.
// The controller takes the slave side; the stage logic (or a bench) takes the master side.
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [7:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles_o;
  logic        stall_timeout_o;
  logic        flush_state_o;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_cycles_o, stall_timeout_o, flush_state_o
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_cycles_o, stall_timeout_o, flush_state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, turns MEM exceptions into a held flush
// with a redirect PC, and tracks stall statistics with a sticky timeout flag.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 255,
  parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e      state_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] saved_pc_q;
  logic [15:0] consec_q;
  logic [31:0] stall_cycles_q;
  logic        timeout_q;

  logic [31:0] exc_pc_c;
  logic [7:0]  req_stall_c;
  logic [7:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        exc_c;

  assign exc_c = (bus.excepttype_i != 32'h0);

  always_comb begin
    exc_pc_c = EXC_VECTOR;
    if (bus.excepttype_i == 32'h1)      exc_pc_c = INT_VECTOR;
    else if (bus.excepttype_i == 32'he) exc_pc_c = bus.cp0_epc_i;

    // Deeper stages win: freezing a later stage must freeze everything upstream.
    req_stall_c = 8'h00;
    if (bus.stallreq_from_mem)     req_stall_c = 8'b0001_1111;
    else if (bus.stallreq_from_ex) req_stall_c = 8'b0000_1111;
    else if (bus.stallreq_from_id) req_stall_c = 8'b0000_0111;
    else if (bus.stallreq_from_if) req_stall_c = 8'b0000_0011;

    stall_c  = 8'h00;
    flush_c  = 1'b0;
    new_pc_c = 32'h0;
    if (!rst) begin
      stall_c  = 8'h00;
    end else if (state_q == FLUSH) begin
      flush_c  = 1'b1;
      new_pc_c = saved_pc_q;
    end else if (exc_c) begin
      flush_c  = 1'b1;
      new_pc_c = exc_pc_c;
    end else begin
      stall_c  = req_stall_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      flush_cnt_q    <= 32'h0;
      saved_pc_q     <= 32'h0;
      consec_q       <= 16'h0;
      stall_cycles_q <= 32'h0;
      timeout_q      <= 1'b0;
    end else begin
      if (stall_c != 8'h00) begin
        stall_cycles_q <= stall_cycles_q + 32'h1;
        if (consec_q != 16'hFFFF) consec_q <= consec_q + 16'h1;
        if ({16'h0, consec_q} + 32'h1 >= STALL_TIMEOUT) timeout_q <= 1'b1;
      end else begin
        consec_q <= 16'h0;
      end

      case (state_q)
        RUN: begin
          if (exc_c) begin
            saved_pc_q <= exc_pc_c;
            if (FLUSH_CYCLES > 1) begin
              state_q     <= FLUSH;
              flush_cnt_q <= 32'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 32'h1;
          if (flush_cnt_q == 32'h1) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.stall           = stall_c;
  assign bus.flush           = flush_c;
  assign bus.new_pc          = new_pc_c;
  assign bus.stall_cycles_o  = stall_cycles_q;
  assign bus.stall_timeout_o = timeout_q;
  assign bus.flush_state_o   = (state_q == FLUSH);

endmodule
